// File: rtl/bcd_cascade_ctrl_pkg.sv
// Shared definitions for the BCD cascade controller.
// State encodings and the largest legal BCD digit.
package bcd_cascade_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SETUP = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_cascade_ctrl_digit.sv
// One BCD digit cell: shift-load, increment with carry, decrement with borrow.
// Shift has priority over counting.
module bcd_digit
    import bcd_cascade_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc,
    input  logic       dec,
    input  logic       shift_en,
    input  logic [3:0] shift_in,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    assign carry_out  = (q == BCD_MAX) & inc;
    assign borrow_out = (q == 4'd0) & dec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= 4'd0;
        end else if (shift_en) begin
            q <= shift_in;
        end else if (inc) begin
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_cascade_ctrl.sv
// Sequencer for a chain of BCD digits: operator entry, run/stop,
// prescaled tick and full-chain carry/borrow ripple.
module bcd_cascade_ctrl
    import bcd_cascade_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                mode,
    input  logic                enter,
    input  logic [3:0]          load,
    input  logic                dir,
    output logic [4*DIGITS-1:0] out,
    output logic [1:0]          state,
    output logic                wrap,
    output logic                err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_t        st;
    logic          enter_q;
    logic [PW-1:0] presc;
    logic          rise;
    logic          tick;
    logic          shift;
    logic [DIGITS:0] cy;
    logic [DIGITS:0] bw;
    logic [3:0]    sin [DIGITS];

    assign rise  = enter & ~enter_q;
    // Leaving RUN this cycle swallows the tick
    assign tick  = (st == ST_RUN) & ~mode & ~rise & (presc == PMAX);
    assign shift = (st == ST_SETUP) & mode & rise & (load <= BCD_MAX);
    assign cy[0] = tick & ~dir;
    assign bw[0] = tick & dir;
    assign state = st;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (g == 0) begin : g_lo
            assign sin[g] = load;
        end else begin : g_hi
            assign sin[g] = out[4*g-4 +: 4];
        end

        bcd_digit u_dig (
            .clk        (clk),
            .rstn       (rstn),
            .inc        (cy[g]),
            .dec        (bw[g]),
            .shift_en   (shift),
            .shift_in   (sin[g]),
            .q          (out[4*g +: 4]),
            .carry_out  (cy[g+1]),
            .borrow_out (bw[g+1])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st      <= ST_IDLE;
            enter_q <= 1'b0;
            presc   <= '0;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            enter_q <= enter;
            wrap    <= cy[DIGITS] | bw[DIGITS];
            if (mode) begin
                st <= ST_SETUP;
                if (st == ST_SETUP && rise) begin
                    err <= (load > BCD_MAX);
                end
            end else begin
                unique case (st)
                    ST_SETUP: begin
                        st  <= ST_IDLE;
                        err <= 1'b0;
                    end
                    ST_IDLE: begin
                        if (rise) begin
                            st    <= ST_RUN;
                            presc <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (rise) begin
                            st <= ST_IDLE;
                        end else begin
                            presc <= (presc == PMAX) ? '0 : presc + 1'b1;
                        end
                    end
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Self-checking bench for bcd_cascade_ctrl, DIGITS=2, TICK_DIV=2.
// Decimal reference model compared every cycle plus literal spot checks.
module tb_bcd_cascade_ctrl;

    localparam int DG = 2;
    localparam int TD = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mode = 1'b0;
    logic          enter = 1'b0;
    logic [3:0]    load = 4'd0;
    logic          dir = 1'b0;
    logic [4*DG-1:0] out;
    logic [1:0]    state;
    logic          wrap;
    logic          err;

    int n_chk = 0;
    int n_fail = 0;

    // behavioural model: value as a decimal integer
    int m_val, m_state, m_presc;
    bit m_err, m_wrap, m_eq;

    bcd_cascade_ctrl #(.DIGITS(DG), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .mode  (mode),
        .enter (enter),
        .load  (load),
        .dir   (dir),
        .out   (out),
        .state (state),
        .wrap  (wrap),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_val = 0; m_state = 0; m_presc = 0;
            m_err = 0; m_wrap = 0; m_eq = 0;
        end else begin
            automatic bit rise = enter && !m_eq;
            m_eq = enter;
            m_wrap = 0;
            if (mode) begin
                if (m_state == 2 && rise) begin
                    if (load <= 9) begin
                        m_val = (m_val * 10 + int'(load)) % 100;
                        m_err = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                m_state = 2;
            end else if (m_state == 2) begin
                m_state = 0;
                m_err = 0;
            end else if (m_state == 0 && rise) begin
                m_state = 1;
                m_presc = 0;
            end else if (m_state == 1 && rise) begin
                m_state = 0;
            end else if (m_state == 1) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (dir) begin
                        if (m_val == 0) begin m_val = 99; m_wrap = 1; end
                        else m_val = m_val - 1;
                    end else begin
                        if (m_val == 99) begin m_val = 0; m_wrap = 1; end
                        else m_val = m_val + 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("out", 32'(out), 32'(bcd(m_val)));
        chk("state", 32'(state), 32'(m_state));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("err", 32'(err), 32'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic [3:0] v);
        load = v;
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic preset(input logic [3:0] hi, input logic [3:0] lo);
        mode = 1'b1;
        step();
        pulse(hi);
        pulse(lo);
        mode = 1'b0;
        step();
    endtask

    task automatic run();
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    initial begin
        bit seen;
        steps(5);
        #3 rstn = 1'b1;
        steps(10);
        chk("rst_out", 32'(out), 32'h00);
        chk("rst_state", 32'(state), 32'd0);

        // setup entry
        mode = 1'b1;
        step();
        pulse(4'd4);
        pulse(4'd7);
        chk("setup_47", 32'(out), 32'h47);
        pulse(4'hA);
        chk("setup_err", 32'(err), 32'd1);
        chk("setup_keep", 32'(out), 32'h47);
        mode = 1'b0;
        step();
        chk("setup_exit", 32'(state), 32'd0);
        chk("setup_errclr", 32'(err), 32'd0);

        // run up, enter held three cycles
        dir = 1'b0;
        enter = 1'b1;
        steps(3);
        enter = 1'b0;
        chk("up_48", 32'(out), 32'h48);
        chk("up_run", 32'(state), 32'd1);
        steps(2);
        chk("up_49", 32'(out), 32'h49);
        steps(2);
        chk("up_50", 32'(out), 32'h50);

        // wrap from 99
        preset(4'd9, 4'd9);
        run();
        step();
        chk("wrap_00", 32'(out), 32'h00);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        step();
        chk("wrap_drop", 32'(wrap), 32'd0);

        // run down
        preset(4'd1, 4'd0);
        dir = 1'b1;
        run();
        step();
        chk("down_09", 32'(out), 32'h09);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = wrap;
        end
        chk("down_wrapseen", 32'(seen), 32'd1);
        chk("down_99", 32'(out), 32'h99);

        // stop and freeze
        pulse(4'd0);
        chk("stop_idle", 32'(state), 32'd0);
        steps(20);
        chk("stop_frozen", 32'(out), 32'h99);

        // mode override on a tick cycle
        dir = 1'b0;
        preset(4'd2, 4'd0);
        run();
        mode = 1'b1;
        step();
        chk("ovr_setup", 32'(state), 32'd2);
        chk("ovr_nostep", 32'(out), 32'h20);
        mode = 1'b0;
        step();

        // async reset mid-count
        preset(4'd6, 4'd3);
        run();
        chk("async_pre", 32'(out), 32'h63);
        #1 rstn = 1'b0;
        #1;
        chk("async_out", 32'(out), 32'h00);
        chk("async_state", 32'(state), 32'd0);
        steps(3);
        #2 rstn = 1'b1;
        step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            mode  = ($urandom_range(0, 11) == 0);
            enter = ($urandom_range(0, 3) == 0);
            load  = 4'($urandom_range(0, 15));
            dir   = 1'($urandom_range(0, 1));
            step();
        end
        mode = 1'b0;
        enter = 1'b0;
        steps(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
